reg_write_arbiter: RTL

//   Shares a bank of NUM_REGS 8-bit enable-gated registers (d_in/en/d_out style)

---
 rtl/reg_write_arbiter_pkg.sv | 14 +
 rtl/reg_write_arbiter_rr_arbiter.sv | 20 ++
 rtl/reg_write_arbiter.sv | 85 ++++++++
 3 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// reg_write_arbiter_pkg: shared FSM encoding, default widths and clog2 helper
package reg_write_arbiter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_WRITE = 1'b1} state_t;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_NUM_REGS = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
    return r;
  endfunction
endpackage

// File: rtl/reg_write_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int N = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx
);
  logic [2*N-1:0] dbl, pick;
  // mask off requests below ptr in the low copy, take the lowest set bit, fold both halves
  always_comb begin
    dbl = {req, req} & ({(2*N){1'b1}} << ptr);
    pick = dbl & (~dbl + 1'b1);
    gnt = pick[N-1:0] | pick[2*N-1:N];
    gnt_idx = '0;
    for (int i = 0; i < N; i++) gnt_idx = gnt[i] ? PTR_W'(i) : gnt_idx;
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin sharing of a register bank write port, one write per two cycles
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      err,
  output logic [NUM_REGS-1:0]       reg_en,
  output logic [DATA_W-1:0]         reg_d,
  output logic                      busy
);
  localparam int PTR_W = clog2(NUM_REQ);
  state_t state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, w_q, w_d, gnt_idx;
  logic [NUM_REQ-1:0] gnt, ack_q, ack_d;
  logic [NUM_REGS-1:0] reg_en_q, reg_en_d;
  logic [DATA_W-1:0] reg_d_q, reg_d_d, sel_data;
  logic [ADDR_W-1:0] sel_addr;
  logic err_q, err_d, busy_q, busy_d, grant, oor;
  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req(req),
    .ptr(ptr_q),
    .gnt(gnt),
    .gnt_idx(gnt_idx)
  );
  // one-hot mux of the winner's address and data
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr = sel_addr | ({ADDR_W{gnt[i]}} & req_addr[i*ADDR_W +: ADDR_W]);
      sel_data = sel_data | ({DATA_W{gnt[i]}} & req_data[i*DATA_W +: DATA_W]);
    end
  end
  // IDLE grants and presents the write; WRITE retires it and rotates the pointer past the winner
  always_comb begin
    grant = (state_q == ST_IDLE) && |req;
    oor = 32'(sel_addr) >= NUM_REGS;
    state_d = grant ? ST_WRITE : ST_IDLE;
    ptr_d = (state_q == ST_WRITE) ? ((w_q == PTR_W'(NUM_REQ - 1)) ? '0 : w_q + PTR_W'(1)) : ptr_q;
    w_d = grant ? gnt_idx : w_q;
    ack_d = grant ? gnt : '0;
    err_d = grant && oor;
    reg_d_d = grant ? sel_data : reg_d_q;
    busy_d = grant;
    reg_en_d = '0;
    for (int j = 0; j < NUM_REGS; j++) reg_en_d[j] = grant && !oor && (sel_addr == ADDR_W'(j));
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q <= '0;
      w_q <= '0;
      ack_q <= '0;
      err_q <= 1'b0;
      reg_en_q <= '0;
      reg_d_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      w_q <= w_d;
      ack_q <= ack_d;
      err_q <= err_d;
      reg_en_q <= reg_en_d;
      reg_d_q <= reg_d_d;
      busy_q <= busy_d;
    end
  end
  assign ack = ack_q;
  assign err = err_q;
  assign reg_en = reg_en_q;
  assign reg_d = reg_d_q;
  assign busy = busy_q;
endmodule
